ripple_count_tracker: RTL and testbench

Downstream consumer of the 4-bit up/down ripple counter. It synchronises the counter's ripple-settled output `q` and direction into the system clock domain, and extends the 4-bit count to a 12-bit position by tracking wrap-arounds in both directions. It flags illegal count jumps as a sticky error and counts steps whose direction disagrees with `dir`. It sits between the ripple counter and any logic that needs a wide, glitch-free position.

---
 rtl/ripple_count_tracker.sv | 141 ++++++++++++++
 tb/tb_ripple_count_tracker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_tracker.sv
// Synchronises a free-running ripple counter into the clk domain and extends it to a
// wide position, flagging illegal jumps and counting steps that disagree with dir.
module ripple_count_tracker #(
    parameter int W   = 4,
    parameter int EXT = 8,
    parameter int MW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       q_in,
    input  logic               dir_in,
    input  logic               clr_err,
    output logic [EXT+W-1:0]   pos,
    output logic               valid,
    output logic               wrap_up,
    output logic               wrap_dn,
    output logic               err,
    output logic [MW-1:0]      mism_cnt
);

    localparam logic [1:0]     S_INIT  = 2'd0;
    localparam logic [1:0]     S_TRACK = 2'd1;
    localparam logic [1:0]     S_ERR   = 2'd2;
    localparam logic [W-1:0]   Q_ONE   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]   Q_MAX   = {W{1'b1}};
    localparam logic [W-1:0]   Q_ZERO  = {W{1'b0}};
    localparam logic [EXT-1:0] E_ONE   = {{(EXT-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0]  M_ONE   = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0]  M_MAX   = {MW{1'b1}};

    logic [W-1:0]   r_s0_q;
    logic [W-1:0]   r_s1_q;
    logic           r_s0_dir;
    logic           r_s1_dir;
    logic [1:0]     r_state;
    logic [1:0]     r_fill;
    logic [W-1:0]   r_last;
    logic [EXT-1:0] r_ext;

    logic [W-1:0]   w_delta;
    logic           w_step_up;
    logic           w_step_dn;
    logic           w_mism_step;
    logic [MW-1:0]  w_mism_inc;

    assign w_delta     = r_s1_q - r_last;
    assign w_step_up   = (w_delta == Q_ONE);
    assign w_step_dn   = (w_delta == Q_MAX);
    assign w_mism_step = (w_step_up && !r_s1_dir) || (w_step_dn && r_s1_dir);
    assign w_mism_inc  = (mism_cnt == M_MAX) ? mism_cnt : (mism_cnt + M_ONE);
    assign pos         = {r_ext, r_last};

    // Two-flop synchroniser; only the second stage is ever consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_q   <= Q_ZERO;
            r_s1_q   <= Q_ZERO;
            r_s0_dir <= 1'b0;
            r_s1_dir <= 1'b0;
        end else begin
            r_s0_q   <= q_in;
            r_s1_q   <= r_s0_q;
            r_s0_dir <= dir_in;
            r_s1_dir <= r_s0_dir;
        end
    end

    // Tracker state machine: acquisition, step tracking with wrap extension, error hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_INIT;
            r_fill   <= 2'd0;
            r_last   <= Q_ZERO;
            r_ext    <= {EXT{1'b0}};
            valid    <= 1'b0;
            wrap_up  <= 1'b0;
            wrap_dn  <= 1'b0;
            err      <= 1'b0;
            mism_cnt <= {MW{1'b0}};
        end else begin
            wrap_up <= 1'b0;
            wrap_dn <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (r_fill == 2'd2) begin
                        r_last  <= r_s1_q;
                        r_ext   <= {EXT{1'b0}};
                        valid   <= 1'b1;
                        r_fill  <= 2'd0;
                        r_state <= S_TRACK;
                    end else begin
                        r_fill <= r_fill + 2'd1;
                    end
                end
                S_TRACK: begin
                    if (w_step_up) begin
                        r_last <= r_s1_q;
                        if (r_last == Q_MAX) begin
                            r_ext   <= r_ext + E_ONE;
                            wrap_up <= 1'b1;
                        end
                    end else if (w_step_dn) begin
                        r_last <= r_s1_q;
                        if (r_last == Q_ZERO) begin
                            r_ext   <= r_ext - E_ONE;
                            wrap_dn <= 1'b1;
                        end
                    end else if (w_delta != Q_ZERO) begin
                        // pos stays at the last good value while the error is held
                        err     <= 1'b1;
                        valid   <= 1'b0;
                        r_state <= S_ERR;
                    end
                    if (clr_err) begin
                        mism_cnt <= {MW{1'b0}};
                    end else if (w_mism_step) begin
                        mism_cnt <= w_mism_inc;
                    end
                end
                S_ERR: begin
                    if (clr_err) begin
                        err      <= 1'b0;
                        mism_cnt <= {MW{1'b0}};
                        r_ext    <= {EXT{1'b0}};
                        r_last   <= Q_ZERO;
                        r_fill   <= 2'd0;
                        r_state  <= S_INIT;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_fill  <= 2'd0;
                    r_last  <= Q_ZERO;
                    r_ext   <= {EXT{1'b0}};
                    valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_count_tracker.sv
// Self-checking bench for ripple_count_tracker: directed scenarios plus a random walk
// checked against an integer-position reference model.
module tb_ripple_count_tracker;

    logic        clk;
    logic        rst;
    logic [3:0]  q_in;
    logic        dir_in;
    logic        clr_err;
    logic [11:0] pos;
    logic        valid;
    logic        wrap_up;
    logic        wrap_dn;
    logic        err;
    logic [7:0]  mism_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: position as a plain integer, two-sample input pipeline.
    int m_pos;
    int m_mism;
    bit m_err;
    bit m_wup;
    bit m_wdn;
    int mq_q[$];
    bit mq_d[$];

    ripple_count_tracker #(.W(4), .EXT(8), .MW(8)) dut (
        .clk(clk), .rst(rst), .q_in(q_in), .dir_in(dir_in), .clr_err(clr_err),
        .pos(pos), .valid(valid), .wrap_up(wrap_up), .wrap_dn(wrap_dn),
        .err(err), .mism_cnt(mism_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    task automatic model_apply(input int q, input bit d);
        int low;
        int diff;
        m_wup = 1'b0;
        m_wdn = 1'b0;
        if (m_err) return;
        low  = m_pos % 16;
        diff = (q - low + 16) % 16;
        if (diff == 1) begin
            if (low == 15) m_wup = 1'b1;
            m_pos = (m_pos + 1) % 4096;
            if (!d && m_mism < 255) m_mism++;
        end else if (diff == 15) begin
            if (low == 0) m_wdn = 1'b1;
            m_pos = (m_pos + 4095) % 4096;
            if (d && m_mism < 255) m_mism++;
        end else if (diff != 0) begin
            m_err = 1'b1;
        end
    endtask

    task automatic drive_edge(input logic [3:0] q, input bit d, input bit c);
        q_in    = q;
        dir_in  = d;
        clr_err = c;
        @(posedge clk);
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic step_clk(input logic [3:0] q, input bit d, input bit c);
        drive_edge(q, d, c);
        m_wup = 1'b0;
        m_wdn = 1'b0;
        mq_q.push_back(int'(q));
        mq_d.push_back(d);
        if (mq_q.size() > 2) model_apply(mq_q.pop_front(), mq_d.pop_front());
        if (c && !m_err) m_mism = 0;
    endtask

    task automatic reset_and_init(input logic [3:0] q, input bit d);
        rst = 1'b1; q_in = q; dir_in = d; clr_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) drive_edge(q, d, 1'b0);
        m_pos = int'(q); m_mism = 0; m_err = 1'b0; m_wup = 1'b0; m_wdn = 1'b0;
        mq_q.delete(); mq_d.delete();
        repeat (2) begin
            mq_q.push_back(int'(q));
            mq_d.push_back(d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; q_in = 4'd5; dir_in = 1'b1; clr_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({pos, valid, wrap_up, wrap_dn, err, mism_cnt} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_state: pos=%h valid=%b err=%b mism=%0d, required all zero", pos, valid, err, mism_cnt);
        end
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            drive_edge(4'd5, 1'b1, 1'b0);
            n_cmp++;
            if (valid !== (e == 3)) begin
                n_fail++;
                $display("FAIL init_valid edge%0d: got %b, required %b", e, valid, (e == 3));
            end
        end
        n_cmp++;
        if (pos !== 12'h005 || err !== 1'b0 || mism_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL init_pos: pos=%h err=%b mism=%0d, required 005/0/0", pos, err, mism_cnt);
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] seq [6] = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd1, 4'd1};
        int n_wup = 0;
        reset_and_init(4'd13, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step_clk(seq[i], 1'b1, 1'b0);
            n_cmp++;
            if (pos !== 12'(m_pos) || wrap_up !== m_wup || wrap_dn !== 1'b0) begin
                n_fail++;
                $display("FAIL up_wrap[%0d]: pos=%h wu=%b wd=%b, required %h/%b/0", i, pos, wrap_up, wrap_dn, 12'(m_pos), m_wup);
            end
            if (wrap_up) begin
                n_wup++;
                n_cmp++;
                if (pos !== 12'h010) begin
                    n_fail++;
                    $display("FAIL up_wrap_pulse_pos: pos=%h, required 010", pos);
                end
            end
        end
        n_cmp++;
        if (pos !== 12'h011 || n_wup != 1) begin
            n_fail++;
            $display("FAIL up_wrap_final: pos=%h pulses=%0d, required 011/1", pos, n_wup);
        end
    endtask

    task automatic test_down_wrap();
        logic [3:0] seq [4] = '{4'd15, 4'd14, 4'd14, 4'd14};
        int  n_wdn = 0;
        bit  saw_fff = 1'b0;
        reset_and_init(4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step_clk(seq[i], 1'b0, 1'b0);
            n_cmp++;
            if (pos !== 12'(m_pos) || wrap_dn !== m_wdn || wrap_up !== 1'b0) begin
                n_fail++;
                $display("FAIL down_wrap[%0d]: pos=%h wd=%b wu=%b, required %h/%b/0", i, pos, wrap_dn, wrap_up, 12'(m_pos), m_wdn);
            end
            if (wrap_dn) n_wdn++;
            if (wrap_dn && pos === 12'hFFF) saw_fff = 1'b1;
        end
        n_cmp++;
        if (pos !== 12'hFFE || n_wdn != 1 || !saw_fff || mism_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL down_wrap_final: pos=%h pulses=%0d fff_pulse=%b mism=%0d, required FFE/1/1/0", pos, n_wdn, saw_fff, mism_cnt);
        end
    endtask

    task automatic test_discontinuity();
        reset_and_init(4'd3, 1'b1);
        step_clk(4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step_clk(4'd7, 1'b1, 1'b0);
        n_cmp++;
        if (err !== 1'b1 || valid !== 1'b0 || pos !== 12'h003 || m_err !== 1'b1) begin
            n_fail++;
            $display("FAIL disc_detect: err=%b valid=%b pos=%h, required 1/0/003", err, valid, pos);
        end
        for (int i = 0; i < 6; i++) begin
            step_clk(4'($urandom_range(0, 15)), 1'b1, 1'b0);
            n_cmp++;
            if (err !== 1'b1 || valid !== 1'b0 || pos !== 12'h003 || wrap_up !== 1'b0 || wrap_dn !== 1'b0) begin
                n_fail++;
                $display("FAIL disc_hold[%0d]: err=%b valid=%b pos=%h, required 1/0/003", i, err, valid, pos);
            end
        end
        q_in = 4'd7;
        repeat (3) drive_edge(4'd7, 1'b1, 1'b0);
        drive_edge(4'd7, 1'b1, 1'b1);
        n_cmp++;
        if (err !== 1'b0 || valid !== 1'b0 || pos !== 12'h000 || mism_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL disc_clear: err=%b valid=%b pos=%h, required 0/0/000", err, valid, pos);
        end
        for (int e = 1; e <= 3; e++) begin
            drive_edge(4'd7, 1'b1, 1'b0);
            n_cmp++;
            if (valid !== (e == 3)) begin
                n_fail++;
                $display("FAIL disc_reacq_valid edge%0d: got %b, required %b", e, valid, (e == 3));
            end
        end
        n_cmp++;
        if (pos !== 12'h007 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL disc_reacq_pos: pos=%h err=%b, required 007/0", pos, err);
        end
    endtask

    task automatic test_mismatch();
        reset_and_init(4'd2, 1'b0);
        for (int i = 0; i < 5; i++) step_clk(4'(3 + (i < 3 ? i : 2)), 1'b0, 1'b0);
        n_cmp++;
        if (mism_cnt !== 8'd3 || err !== 1'b0 || pos !== 12'h005 || mism_cnt !== 8'(m_mism)) begin
            n_fail++;
            $display("FAIL mism_three: mism=%0d err=%b pos=%h, required 3/0/005", mism_cnt, err, pos);
        end
        step_clk(4'd5, 1'b0, 1'b1);
        n_cmp++;
        if (mism_cnt !== 8'd0 || pos !== 12'h005) begin
            n_fail++;
            $display("FAIL mism_clear: mism=%0d pos=%h, required 0/005", mism_cnt, pos);
        end
        for (int i = 1; i <= 302; i++) begin
            step_clk(4'((5 + (i <= 300 ? i : 300)) % 16), 1'b0, 1'b0);
            n_cmp++;
            if (mism_cnt !== 8'(m_mism) || pos !== 12'(m_pos)) begin
                n_fail++;
                $display("FAIL mism_run[%0d]: mism=%0d pos=%h, required %0d/%h", i, mism_cnt, pos, m_mism, 12'(m_pos));
            end
        end
        n_cmp++;
        if (mism_cnt !== 8'd255 || pos !== 12'h131) begin
            n_fail++;
            $display("FAIL mism_saturate: mism=%0d pos=%h, required 255/131", mism_cnt, pos);
        end
    endtask

    task automatic test_mid_reset();
        reset_and_init(4'd15, 1'b1);
        step_clk(4'd0, 1'b0, 1'b0);
        step_clk(4'd1, 1'b0, 1'b0);
        step_clk(4'd1, 1'b0, 1'b0);
        step_clk(4'd1, 1'b0, 1'b0);
        n_cmp++;
        if (pos !== 12'h011 || mism_cnt !== 8'd2 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup: pos=%h mism=%0d valid=%b, required 011/2/1", pos, mism_cnt, valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({pos, valid, wrap_up, wrap_dn, err, mism_cnt} !== 25'd0) begin
            n_fail++;
            $display("FAIL midrst_async: pos=%h valid=%b err=%b mism=%0d, required all zero", pos, valid, err, mism_cnt);
        end
        q_in = 4'd9;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            drive_edge(4'd9, 1'b1, 1'b0);
            n_cmp++;
            if (valid !== (e == 3)) begin
                n_fail++;
                $display("FAIL midrst_valid edge%0d: got %b, required %b", e, valid, (e == 3));
            end
        end
        n_cmp++;
        if (pos !== 12'h009) begin
            n_fail++;
            $display("FAIL midrst_pos: pos=%h, required 009", pos);
        end
    endtask

    task automatic test_random_walk();
        logic [3:0] q;
        bit         d;
        bit         c;
        int         mv;
        q = 4'($urandom_range(0, 15));
        reset_and_init(q, 1'b1);
        for (int i = 0; i < 400; i++) begin
            mv = $urandom_range(0, 2);
            if (mv == 1) q = q + 4'd1;
            else if (mv == 2) q = q - 4'd1;
            d = ($urandom_range(0, 3) != 0) ? (mv != 2) : (mv == 2);
            c = ($urandom_range(0, 19) == 0);
            step_clk(q, d, c);
            n_cmp++;
            if (pos !== 12'(m_pos) || wrap_up !== m_wup || wrap_dn !== m_wdn ||
                mism_cnt !== 8'(m_mism) || err !== 1'b0 || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL random[%0d]: pos=%h wu=%b wd=%b mism=%0d err=%b valid=%b, required %h/%b/%b/%0d/0/1",
                         i, pos, wrap_up, wrap_dn, mism_cnt, err, valid, 12'(m_pos), m_wup, m_wdn, m_mism);
            end
        end
    endtask

    initial begin
        rst = 1'b1; q_in = 4'd0; dir_in = 1'b0; clr_err = 1'b0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_discontinuity();
        test_mismatch();
        test_mid_reset();
        test_random_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
